systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter depth, default 4: array dimension, i.e. lanes and matrix rows/columns.
REQ-002 SHALL have parameter bit_width, default 8: element width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1  write one matrix row this cycle.
REQ-006 SHALL have port wr_sel  in  1  write target: 0 = data buffer, 1 = weight buffer.
REQ-007 SHALL have port wr_row  in  clog2(depth)  row index written.
REQ-008 SHALL have port wr_vec  in  bit_width*depth  row contents; slice [bit_width*c +: bit_width] is column c.
REQ-009 SHALL have port start  in  1  request one feed run.
REQ-010 SHALL have port data_arr  out  bit_width*depth  skewed data lanes to the array.
REQ-011 SHALL have port wt_arr  out  bit_width*depth  skewed weight lanes to the array.
REQ-012 SHALL have port control  out  1  array enable; high while busy.
REQ-013 SHALL have port busy  out  1  run in progress.
REQ-014 SHALL have port done  out  1  one-cycle end-of-run pulse.

Function
REQ-015 SHALL hold two depth x depth buffers, D (data) and W (weight); in IDLE, wr_en writes wr_vec into row wr_row of the buffer selected by wr_sel; contents are retained across runs.
REQ-016 SHALL implement FSM states IDLE, FEED, FLUSH; IDLE->FEED when start=1 in IDLE; FEED->FLUSH after 2*depth-1 cycles; FLUSH->IDLE after depth cycles.
REQ-017 SHALL ignore wr_en and start while busy; SHALL drop wr_en when it coincides with an accepted start.
REQ-018 SHALL register all outputs; in FEED cycle k (0..2*depth-2), lane i of data_arr SHALL equal D[k-i][i] and lane i of wt_arr SHALL equal W[k-i][i] when 0<=k-i<depth, otherwise 0.
REQ-019 SHALL drive data_arr = wt_arr = 0 in IDLE and FLUSH.
REQ-020 SHALL assert busy and control from FEED cycle 0 through the last FLUSH cycle: 3*depth-1 cycles total (11 for depth=4).
REQ-021 SHALL pulse done for exactly one cycle, on the first IDLE cycle after FLUSH.
REQ-022 SHALL accept a start that arrives in the same cycle as done; the next run's FEED cycle 0 then follows immediately.
REQ-023 SHALL wrap the feed and flush counters to 0 on each state entry.

Reset
REQ-024 While reset is high, SHALL force state IDLE, counters 0, and data_arr, wt_arr, control, busy and done to 0, independent of clk.
REQ-025 Reset SHALL clear D and W to 0, and reset mid-run SHALL abort the run without asserting done.

Configuration
REQ-026 With macro FEEDER_RUN_COUNT_EN defined, SHALL add output run_cnt (8 bits), reset to 0, incremented when done pulses, wrapping 255->0; without the macro, the port and its logic SHALL be absent.

Verification
REQ-027 Load D = W = identity and start -> lane i is nonzero (value 1) only at FEED cycle 2i; busy lasts 11 cycles; done pulses once.
REQ-028 Load D[r][c] = 4r+c+1 and start -> FEED cycle 3 gives data_arr lanes {0,1,2,3} = {13,10,7,4}; cycle 6 gives lane3 = 16 and all other lanes 0.
REQ-029 Pulse start and wr_en during busy -> no restart, buffers unchanged, and the next run reproduces the previous outputs.
REQ-030 Assert reset at FEED cycle 2 -> all outputs 0 at once, no done, buffers read back 0 on the next run.
REQ-031 Hold start high continuously -> back-to-back runs, each with 11 busy cycles; done and FEED cycle 0 of the next run are adjacent.
REQ-032 With FEEDER_RUN_COUNT_EN defined, run 257 times -> run_cnt = 1.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: stores a depth x depth data matrix D and weight
// matrix W, then streams them diagonally skewed into a systolic array.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_row write one row of D (wr_sel=0) or W (wr_sel=1)
//   wr_vec              row contents, column c at [bit_width*c +: bit_width]
//   start               request one feed run (IDLE only)
//   data_arr, wt_arr    registered skewed lanes, lane i = D/W[k-i][i]
//   control, busy       high from FEED cycle 0 through the last FLUSH cycle
//   done                one-cycle pulse on the first IDLE cycle after FLUSH
//   run_cnt             8-bit count of completed runs, only present when
//                       the macro FEEDER_RUN_COUNT_EN is defined
module systolic_feeder #(
    parameter int depth     = 4,
    parameter int bit_width = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(depth)-1:0]     wr_row,
    input  logic [bit_width*depth-1:0]   wr_vec,
    input  logic                         start,
    output logic [bit_width*depth-1:0]   data_arr,
    output logic [bit_width*depth-1:0]   wt_arr,
    output logic                         control,
    output logic                         busy,
`ifdef FEEDER_RUN_COUNT_EN
    output logic                         done,
    output logic [7:0]                   run_cnt
`else
    output logic                         done
`endif
);

    localparam int CW = $clog2(2 * depth);
    localparam logic [CW-1:0] LAST_FEED  = CW'(2 * depth - 2);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(depth - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       we;
    logic                       done_d;
    logic                       busy_d;
    logic [bit_width*depth-1:0] data_d, wt_d;

    logic [bit_width-1:0] d_mem [depth][depth];
    logic [bit_width-1:0] w_mem [depth][depth];

    // One counter serves both FEED and FLUSH; it restarts at 0 on
    // every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FEED;
                    cnt_d   = '0;
                end else if (wr_en) begin
                    we = 1'b1;
                end
            end
            FEED: begin
                if (cnt_q == LAST_FEED) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == LAST_FLUSH) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state/count so that the
    // registered lanes line up with the cycle they describe.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_q == FLUSH) && (state_d == IDLE);
        data_d = '0;
        wt_d   = '0;
        for (int i = 0; i < depth; i++) begin
            for (int r = 0; r < depth; r++) begin
                if (state_d == FEED && int'(cnt_d) == r + i) begin
                    data_d[i*bit_width +: bit_width] = d_mem[r][i];
                    wt_d[i*bit_width +: bit_width]   = w_mem[r][i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_arr <= '0;
            wt_arr   <= '0;
            control  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_arr <= data_d;
            wt_arr   <= wt_d;
            control  <= busy_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < depth; r++) begin
                for (int c = 0; c < depth; c++) begin
                    d_mem[r][c] <= '0;
                    w_mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < depth; c++) begin
                if (wr_sel) begin
                    w_mem[wr_row][c] <= wr_vec[c*bit_width +: bit_width];
                end else begin
                    d_mem[wr_row][c] <= wr_vec[c*bit_width +: bit_width];
                end
            end
        end
    end

`ifdef FEEDER_RUN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= 8'd0;
        end else if (done_d) begin
            run_cnt <= run_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed testbench for systolic_feeder (depth=4, bit_width=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_systolic_feeder;

    localparam int DEP = 4;
    localparam int BW  = 8;
    localparam int NC  = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic              wr_sel = 1'b0;
    logic [1:0]        wr_row = '0;
    logic [BW*DEP-1:0] wr_vec = '0;
    logic              start = 1'b0;
    logic [BW*DEP-1:0] data_arr, wt_arr;
    logic              control, busy, done;
`ifdef FEEDER_RUN_COUNT_EN
    logic [7:0]        run_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [BW-1:0]     dm [DEP][DEP];
    logic [BW-1:0]     wm [DEP][DEP];
    logic [BW*DEP-1:0] cap_d [NC];
    logic [BW*DEP-1:0] cap_w [NC];
    logic              cap_b [NC];
    logic              cap_c [NC];
    logic              cap_o [NC];

    systolic_feeder #(.depth(DEP), .bit_width(BW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_vec(wr_vec), .start(start),
        .data_arr(data_arr), .wt_arr(wt_arr), .control(control),
`ifdef FEEDER_RUN_COUNT_EN
        .busy(busy), .done(done), .run_cnt(run_cnt)
`else
        .busy(busy), .done(done)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mexp(input bit is_w, input int k,
                                           input int i);
        int r;
        r = k - i;
        if (r < 0 || r >= DEP) return '0;
        return is_w ? wm[r][i] : dm[r][i];
    endfunction

    task automatic write_row(input bit sel, input int row,
                             input logic [BW*DEP-1:0] vec);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_sel = sel;
        wr_row = 2'(row);
        wr_vec = vec;
        for (int c = 0; c < DEP; c++) begin
            if (sel) wm[row][c] = vec[c*BW +: BW];
            else     dm[row][c] = vec[c*BW +: BW];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts one run (optionally with a coincident write) and records
    // NC cycles from FEED cycle 0; at cycle poke it pulses start and a
    // write of all-ones into D row 0.
    task automatic capture_run(input int poke, input bit coinc);
        @(negedge clk);
        start  = 1'b1;
        wr_en  = coinc;
        wr_sel = 1'b0;
        wr_row = 2'd0;
        wr_vec = '1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int n = 0; n < NC; n++) begin
            cap_d[n] = data_arr;
            cap_w[n] = wt_arr;
            cap_b[n] = busy;
            cap_c[n] = control;
            cap_o[n] = done;
            start = (n == poke);
            wr_en = (n == poke);
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic check_run(input string tag);
        int nb, nd;
        nb = 0;
        nd = 0;
        for (int n = 0; n < NC; n++) begin
            if (cap_b[n]) nb++;
            if (cap_o[n]) nd++;
            if (cap_c[n] !== cap_b[n]) begin
                vectors++;
                errors++;
                $display("FAIL %s control cyc %0d: got %b want %b",
                         tag, n, cap_c[n], cap_b[n]);
            end
        end
        vectors++;
        if (nb != 3 * DEP - 1 || cap_b[0] !== 1'b1 || cap_b[10] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, nb, 3*DEP-1);
        end
        vectors++;
        if (nd != 1 || cap_o[11] !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %0d pulses, at11=%b want 1,1",
                     tag, nd, cap_o[11]);
        end
        for (int n = 0; n < NC; n++) begin
            for (int i = 0; i < DEP; i++) begin
                logic [BW-1:0] ed, ew;
                ed = (n < 2*DEP-1) ? mexp(1'b0, n, i) : '0;
                ew = (n < 2*DEP-1) ? mexp(1'b1, n, i) : '0;
                vectors++;
                if (cap_d[n][i*BW +: BW] !== ed ||
                    cap_w[n][i*BW +: BW] !== ew) begin
                    errors++;
                    $display("FAIL %s lane cyc%0d l%0d: got d=%h w=%h want d=%h w=%h",
                             tag, n, i, cap_d[n][i*BW +: BW],
                             cap_w[n][i*BW +: BW], ed, ew);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int r = 0; r < DEP; r++)
            for (int c = 0; c < DEP; c++) begin
                dm[r][c] = '0;
                wm[r][c] = '0;
            end
        repeat (2) @(negedge clk);
        vectors++;
        if ({data_arr, wt_arr, control, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h %b%b%b want 0",
                     data_arr, wt_arr, control, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        for (int r = 0; r < DEP; r++) begin
            write_row(1'b0, r, (BW*DEP)'(1) << (BW*r));
            write_row(1'b1, r, (BW*DEP)'(1) << (BW*r));
        end
        capture_run(-1, 1'b0);
        for (int n = 0; n < 11; n++) begin
            for (int i = 0; i < DEP; i++) begin
                logic [BW-1:0] e;
                e = (n == 2*i) ? 8'd1 : 8'd0;
                vectors++;
                if (cap_d[n][i*BW +: BW] !== e || cap_w[n][i*BW +: BW] !== e) begin
                    errors++;
                    $display("FAIL identity cyc%0d l%0d: got %h/%h want %h",
                             n, i, cap_d[n][i*BW +: BW],
                             cap_w[n][i*BW +: BW], e);
                end
            end
        end
        check_run("identity");
    endtask

    task automatic test_ramp();
        for (int r = 0; r < DEP; r++) begin
            logic [BW*DEP-1:0] vd, vw;
            for (int c = 0; c < DEP; c++) begin
                vd[c*BW +: BW] = 8'(4*r + c + 1);
                vw[c*BW +: BW] = 8'(16*(r + 1) + c);
            end
            write_row(1'b0, r, vd);
            write_row(1'b1, r, vw);
        end
        capture_run(-1, 1'b0);
        vectors++;
        if (cap_d[3] !== 32'h04070a0d) begin
            errors++;
            $display("FAIL ramp_data_c3: got %h want 04070a0d", cap_d[3]);
        end
        vectors++;
        if (cap_d[6] !== 32'h10000000) begin
            errors++;
            $display("FAIL ramp_data_c6: got %h want 10000000", cap_d[6]);
        end
        vectors++;
        if (cap_w[3] !== 32'h13223140) begin
            errors++;
            $display("FAIL ramp_wt_c3: got %h want 13223140", cap_w[3]);
        end
        check_run("ramp");
    endtask

    task automatic test_busy_ignore();
        capture_run(3, 1'b0);
        check_run("busy_poke");
        capture_run(-1, 1'b1);
        check_run("coinc_write");
    endtask

    task automatic test_back_to_back();
        int seen_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        seen_done = 0;
        for (int n = 0; n < 36; n++) begin
            bit eb;
            eb = (n % 12) != 11;
            vectors++;
            if (busy !== eb || done !== !eb) begin
                errors++;
                $display("FAIL b2b cyc%0d: got busy=%b done=%b want %b %b",
                         n, busy, done, eb, !eb);
            end
            if (n == 12) begin
                vectors++;
                if (data_arr[7:0] !== mexp(1'b0, 0, 0)) begin
                    errors++;
                    $display("FAIL b2b_feed0: got %h want %h",
                             data_arr[7:0], mexp(1'b0, 0, 0));
                end
            end
            if (n == 35) start = 1'b0;
            @(negedge clk);
        end
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int nd;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({data_arr, wt_arr, control, busy, done} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got %h/%h %b%b%b want 0",
                     data_arr, wt_arr, control, busy, done);
        end
        for (int r = 0; r < DEP; r++)
            for (int c = 0; c < DEP; c++) begin
                dm[r][c] = '0;
                wm[r][c] = '0;
            end
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int n = 0; n < 15; n++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        vectors++;
        if (nd != 0) begin
            errors++;
            $display("FAIL midreset_nodone: got %0d active cycles want 0", nd);
        end
        capture_run(-1, 1'b0);
        check_run("post_reset");
    endtask

`ifdef FEEDER_RUN_COUNT_EN
    task automatic test_run_count();
        int nd;
        vectors++;
        if (run_cnt !== 8'd0) begin
            errors++;
            $display("FAIL run_cnt_init: got %0d want 0", run_cnt);
        end
        @(negedge clk);
        start = 1'b1;
        nd = 0;
        for (int n = 0; n < 4000 && nd < 257; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        start = 1'b0;
        vectors++;
        if (nd != 257 || run_cnt !== 8'd1) begin
            errors++;
            $display("FAIL run_cnt_wrap: got runs=%0d cnt=%0d want 257 1",
                     nd, run_cnt);
        end
        repeat (15) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
`ifdef FEEDER_RUN_COUNT_EN
        test_run_count();
`endif
        test_identity();
        test_ramp();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
